// File: rtl/keypad_debounce_encoder_if.sv
// ----------------------------------------------------------------------------
// keypad_debounce_encoder_if
//   Bundles the keypad front-end signals so the encoder and its consumer share
//   one typed connection.
//
//   Signals
//     key_in      [11:0] raw key lines, active-high, asynchronous to clk
//     key_value   [3:0]  code of the last accepted key (4'hF = none since reset)
//     key_valid          one-cycle accept pulse
//     key_held           single accepted key currently held
//     multi_press        chord detected, input ignored until full release
//     dbg_state   [1:0]  encoder FSM state (0 idle, 1 press, 2 multi)
//
//   Modports
//     master : the encoder (drives the outputs, reads key_in)
//     slave  : the consumer / key source (drives key_in, reads the outputs)
//
//   Handshake: key_valid is a push-only strobe with no ready. key_value is
//   meaningful in the cycle key_valid is high and keeps that value afterwards;
//   the consumer must take the event in that cycle.
// ----------------------------------------------------------------------------
interface keypad_debounce_encoder_if;
    logic [11:0] key_in;
    logic [3:0]  key_value;
    logic        key_valid;
    logic        key_held;
    logic        multi_press;
    logic [1:0]  dbg_state;

    modport master (
        input  key_in,
        output key_value,
        output key_valid,
        output key_held,
        output multi_press,
        output dbg_state
    );

    modport slave (
        output key_in,
        input  key_value,
        input  key_valid,
        input  key_held,
        input  multi_press,
        input  dbg_state
    );
endinterface

// File: rtl/keypad_debounce_encoder.sv
// ----------------------------------------------------------------------------
// keypad_debounce_encoder
//   Front-end for the 12-key parallel keypad: synchronises and debounces the
//   raw key lines, rejects chords and encodes a single key to a 4-bit code,
//   emitting a one-cycle accept pulse.
//
//   Ports
//     clk     system clock
//     rst_n   asynchronous active-low reset, synchronous release
//     kp_if   keypad_debounce_encoder_if.master (key_in in; key_value,
//             key_valid, key_held, multi_press, dbg_state out)
//
//   Parameters
//     CLK_FREQ_HZ      clock frequency; one debounce tick = CLK_FREQ_HZ/1000 cycles
//     DEBOUNCE_MS      identical consecutive tick samples needed to accept a vector
//     REPEAT_DELAY_MS  ticks held before the first auto-repeat pulse
//     REPEAT_RATE_MS   ticks between subsequent auto-repeat pulses
//
//   Build option
//     KEYPAD_AUTOREPEAT_EN  when defined, a held key re-pulses key_valid after
//                           REPEAT_DELAY_MS ticks and then every REPEAT_RATE_MS
//                           ticks. Undefined: exactly one pulse per press.
//
//   Key code map: bits 0..8 -> 1..9, bit 9 ('*') -> 10, bit 10 -> 0,
//   bit 11 ('#') -> 11.
// ----------------------------------------------------------------------------
module keypad_debounce_encoder #(
    parameter int CLK_FREQ_HZ     = 50_000_000,
    parameter int DEBOUNCE_MS     = 20,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 100
) (
    input  logic                              clk,
    input  logic                              rst_n,
    keypad_debounce_encoder_if.master         kp_if
);

    localparam int TICK_CYC = CLK_FREQ_HZ / 1000;
    localparam int TICK_W   = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam int DB_W     = $clog2(DEBOUNCE_MS + 1);

    // Elaboration-time sanity check of the configuration.
    if (TICK_CYC < 1 || DEBOUNCE_MS < 1 || REPEAT_RATE_MS < 1 ||
        REPEAT_DELAY_MS < REPEAT_RATE_MS) begin : g_bad_cfg
        $error("keypad_debounce_encoder: invalid timing parameters");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRESS = 2'd1,
        S_MULTI = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Two-flop synchroniser; everything downstream uses r_sync2.
    // ------------------------------------------------------------------
    logic [11:0] r_sync1;
    logic [11:0] r_sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= kp_if.key_in;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------
    // 1 ms tick: free-running counter, tick during the terminal count.
    // ------------------------------------------------------------------
    logic [TICK_W-1:0] r_tick_cnt;
    logic              w_tick;

    assign w_tick = (r_tick_cnt == TICK_W'(TICK_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Debounce: a vector must be seen on DEBOUNCE_MS consecutive ticks.
    // The debounced vector is loaded in the same tick the count reaches
    // the threshold, so the next-count value is what gets compared.
    // ------------------------------------------------------------------
    logic [11:0]     r_cand;
    logic [11:0]     r_deb;
    logic [DB_W-1:0] r_stable_cnt;
    logic [11:0]     w_cand_nxt;
    logic [DB_W-1:0] w_cnt_nxt;

    always_comb begin
        w_cand_nxt = r_cand;
        w_cnt_nxt  = r_stable_cnt;
        if (r_sync2 != r_cand) begin
            w_cand_nxt = r_sync2;
            w_cnt_nxt  = DB_W'(1);
        end else if (r_stable_cnt != DB_W'(DEBOUNCE_MS)) begin
            w_cnt_nxt = r_stable_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cand       <= '0;
            r_stable_cnt <= '0;
            r_deb        <= '0;
        end else if (w_tick) begin
            r_cand       <= w_cand_nxt;
            r_stable_cnt <= w_cnt_nxt;
            if (w_cnt_nxt == DB_W'(DEBOUNCE_MS)) begin
                r_deb <= w_cand_nxt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Encoder (only meaningful for a one-hot input).
    // ------------------------------------------------------------------
    function automatic logic [3:0] f_encode(input logic [11:0] v);
        logic [3:0] c;
        c = 4'hF;
        for (int i = 0; i < 9; i++) begin
            if (v[i]) c = 4'(i + 1);
        end
        if (v[9])  c = 4'd10;
        if (v[10]) c = 4'd0;
        if (v[11]) c = 4'd11;
        return c;
    endfunction

    logic w_deb_zero;
    logic w_deb_onehot;

    assign w_deb_zero   = (r_deb == 12'd0);
    assign w_deb_onehot = !w_deb_zero && ((r_deb & (r_deb - 12'd1)) == 12'd0);

    // ------------------------------------------------------------------
    // FSM: state register / next-state / outputs.
    // r_press_vec remembers the accepted key so a swap A->B is a chord.
    // ------------------------------------------------------------------
    state_t      r_state;
    state_t      w_state_nxt;
    logic [11:0] r_press_vec;
    logic [3:0]  r_key_value;
    logic        r_key_valid;
    logic        w_accept;
    logic        w_rpt_fire;
    logic        w_key_valid_nxt;
    logic [3:0]  w_key_value_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_deb_onehot)     w_state_nxt = S_PRESS;
                else if (!w_deb_zero) w_state_nxt = S_MULTI;
            end
            S_PRESS: begin
                if (w_deb_zero)                w_state_nxt = S_IDLE;
                else if (r_deb != r_press_vec) w_state_nxt = S_MULTI;
            end
            S_MULTI: begin
                // Dropping back to one key does not re-arm; only full release.
                if (w_deb_zero) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_accept        = (r_state == S_IDLE) && w_deb_onehot;
        w_key_valid_nxt = w_accept || w_rpt_fire;
        w_key_value_nxt = w_accept ? f_encode(r_deb) : r_key_value;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_value <= 4'hF;
            r_key_valid <= 1'b0;
            r_press_vec <= '0;
        end else begin
            r_key_value <= w_key_value_nxt;
            r_key_valid <= w_key_valid_nxt;
            if (w_accept) begin
                r_press_vec <= r_deb;
            end
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    // ------------------------------------------------------------------
    // Auto-repeat: count ticks while pressed. After firing at the delay the
    // counter is rewound so the next fire is REPEAT_RATE_MS ticks later.
    // Repeat pulses only occur in PRESS and accept pulses only from IDLE,
    // so key_valid can never be high on two consecutive cycles.
    // ------------------------------------------------------------------
    localparam int RPT_W = $clog2(REPEAT_DELAY_MS + 1);

    logic [RPT_W-1:0] r_rpt_cnt;

    assign w_rpt_fire = w_tick && (r_state == S_PRESS) &&
                        (r_rpt_cnt == RPT_W'(REPEAT_DELAY_MS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rpt_cnt <= '0;
        end else if (r_state != S_PRESS) begin
            r_rpt_cnt <= '0;
        end else if (w_tick) begin
            if (w_rpt_fire) begin
                r_rpt_cnt <= RPT_W'(REPEAT_DELAY_MS - REPEAT_RATE_MS);
            end else begin
                r_rpt_cnt <= r_rpt_cnt + 1'b1;
            end
        end
    end
`else
    assign w_rpt_fire = 1'b0;
`endif

    assign kp_if.key_value   = r_key_value;
    assign kp_if.key_valid   = r_key_valid;
    assign kp_if.key_held    = (r_state == S_PRESS);
    assign kp_if.multi_press = (r_state == S_MULTI);
    assign kp_if.dbg_state   = r_state;

endmodule

// File: tb/tb_keypad_debounce_encoder.sv
// ----------------------------------------------------------------------------
// tb_keypad_debounce_encoder
//   Drives the keypad with directed scenarios followed by random key vectors.
//   Key changes are placed mid-way between debounce ticks so each segment of
//   n ticks delivers exactly n samples to the debouncer. The reference model
//   works on those samples: a vector becomes debounced once the last
//   DEBOUNCE_MS samples agree, and the press/chord rules turn debounced
//   changes into expected accept codes queued in exp_q.
// ----------------------------------------------------------------------------
module tb_keypad_debounce_encoder;

    localparam int CLK_HZ    = 10_000;
    localparam int DEB       = 4;
    localparam int RPT_DELAY = 10;
    localparam int RPT_RATE  = 5;
    localparam int TICK_CLK  = CLK_HZ / 1000;
    localparam int HALF_TICK = TICK_CLK / 2;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    keypad_debounce_encoder_if kp ();

    keypad_debounce_encoder #(
        .CLK_FREQ_HZ    (CLK_HZ),
        .DEBOUNCE_MS    (DEB),
        .REPEAT_DELAY_MS(RPT_DELAY),
        .REPEAT_RATE_MS (RPT_RATE)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .kp_if(kp)
    );

    // ---------------- scoreboard ----------------
    logic [3:0] exp_q[$];
    int         n_tests;
    int         n_fail;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [3:0]  code_tab [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                                   4'd7, 4'd8, 4'd9, 4'd10, 4'd0, 4'd11};
    logic [11:0] m_hist[$];
    logic [11:0] m_deb;
    int          m_state;      // 0 idle, 1 single key pressed, 2 chord
    logic [3:0]  m_value;
    int          m_held_ticks;

    task automatic model_reset();
        m_hist.delete();
        exp_q.delete();
        m_deb        = '0;
        m_state      = 0;
        m_value      = 4'hF;
        m_held_ticks = 0;
    endtask

    task automatic model_debounced_change(input logic [11:0] v);
        int n;
        n = $countones(v);
        case (m_state)
            0: begin
                if (n == 1) begin
                    m_state = 1;
                    m_held_ticks = 0;
                    for (int i = 0; i < 12; i++) begin
                        if (v[i]) m_value = code_tab[i];
                    end
                    exp_q.push_back(m_value);
                end else if (n >= 2) begin
                    m_state = 2;
                end
            end
            1: m_state = (n == 0) ? 0 : 2;
            default: if (n == 0) m_state = 0;
        endcase
    endtask

    task automatic model_sample(input logic [11:0] v);
        logic same;
`ifdef KEYPAD_AUTOREPEAT_EN
        if (m_state == 1) begin
            m_held_ticks++;
            if (m_held_ticks >= RPT_DELAY && (m_held_ticks - RPT_DELAY) % RPT_RATE == 0)
                exp_q.push_back(m_value);
        end
`endif
        m_hist.push_back(v);
        if (m_hist.size() > DEB) void'(m_hist.pop_front());
        if (m_hist.size() == DEB) begin
            same = 1'b1;
            foreach (m_hist[i]) if (m_hist[i] != v) same = 1'b0;
            if (same && v != m_deb) begin
                m_deb = v;
                model_debounced_change(v);
            end
        end
    endtask

    // ---------------- pulse monitor ----------------
    logic prev_kv;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_kv = 1'b0;
        end else begin
            if (kp.key_valid) begin
                check("no_consecutive_valid", prev_kv, 1'b0);
                check("pulse_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) check("pulse_value", kp.key_value, exp_q.pop_front());
            end
            prev_kv = kp.key_valid;
        end
    end

    // ---------------- driver tasks ----------------
    // Entered and left on the negedge halfway between two tick samples.
    task automatic hold_ticks(input logic [11:0] v, input int n);
        kp.key_in = v;
        for (int i = 0; i < n; i++) begin
            repeat (HALF_TICK) @(posedge clk);
            model_sample(v);
            repeat (HALF_TICK) @(posedge clk);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_key_value", kp.key_value, 4'hF);
        check("rst_key_valid", kp.key_valid, 1'b0);
        check("rst_key_held", kp.key_held, 1'b0);
        check("rst_multi", kp.multi_press, 1'b0);
        check("rst_state", kp.dbg_state, 2'd0);
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (HALF_TICK) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic seg_check(input string tag);
        check({tag, "_pending"}, exp_q.size(), 0);
        check({tag, "_value"}, kp.key_value, m_value);
        check({tag, "_held"}, kp.key_held, m_state == 1);
        check({tag, "_multi"}, kp.multi_press, m_state == 2);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [11:0] v;
        int          kind;
        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b1;
        kp.key_in = '0;
        model_reset();

        // 1: reset state, then key 0 (bit 10) held for 10 ticks
        do_reset();
        hold_ticks(12'h000, 2);
        seg_check("t1_idle");
        hold_ticks(12'h400, 10);
        seg_check("t1_press");
        hold_ticks(12'h000, 6);
        seg_check("t1_release");

        // 2: '#' bouncing 2 ticks high / 1 low, then held
        for (int i = 0; i < 5; i++) begin
            hold_ticks(12'h800, 2);
            hold_ticks(12'h000, 1);
        end
        seg_check("t2_bounce");
        hold_ticks(12'h800, 6);
        seg_check("t2_press");
        hold_ticks(12'h000, 6);

        // 3: key 1 accepted, key 5 added, key 1 released, all released
        hold_ticks(12'h001, 6);
        seg_check("t3_single");
        hold_ticks(12'h011, 6);
        seg_check("t3_chord");
        hold_ticks(12'h010, 6);
        seg_check("t3_drop_one");
        hold_ticks(12'h000, 6);
        seg_check("t3_release");

        // 4: bits 2 and 9 together straight after reset
        do_reset();
        hold_ticks(12'h204, 6);
        seg_check("t4_chord");
        hold_ticks(12'h000, 6);
        seg_check("t4_release");

        // 5: reset mid-debounce with the key kept held
        hold_ticks(12'h100, 2);
        do_reset();
        hold_ticks(12'h100, 6);
        seg_check("t5_press");
        hold_ticks(12'h000, 6);
        seg_check("t5_release");

        // 6: long hold (auto-repeat pulses only with the feature built in)
        hold_ticks(12'h002, 34);
        seg_check("t6_hold");
        hold_ticks(12'h000, 6);
        seg_check("t6_release");

        // random segments: releases, single keys, pairs, arbitrary vectors
        for (int s = 0; s < 40; s++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0: v = 12'h000;
                1: v = 12'h001 << $urandom_range(0, 11);
                2: v = (12'h001 << $urandom_range(0, 11)) | (12'h001 << $urandom_range(0, 11));
                default: v = 12'($urandom_range(0, 4095));
            endcase
            hold_ticks(v, $urandom_range(1, 7));
            seg_check("rnd");
        end

        hold_ticks(12'h000, 6);
        seg_check("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
